// File: rtl/bus_responder.sv
`default_nettype none
// ==========================================================================
// bus_responder : demultiplexes the tt_um_6502 external bus and serves it from a byte RAM.
// Optional macro BUS_RESPONDER_VECTOR_EN pins $FFFC/$FFFD to RESET_VEC.  Rev 1.0
// ==========================================================================
module bus_responder #(
  parameter logic [15:0] BASE      = 16'h0000,
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  FILL      = 8'hEA,
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi,
  input  logic [7:0]  ab_mux,
  input  logic [7:0]  bus_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [15:0] addr,
  output logic        rw_out,
  output logic        cycle_strobe,
  output logic        wr_strobe,
  output logic [15:0] cycle_count
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [16:0] LIMIT = {1'b0, BASE} + 17'(DEPTH);
`ifdef BUS_RESPONDER_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        phi_q;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d, wd_q, wd_d;
  logic        rw_q, rw_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_out_q, rw_out_d;
  logic        cycle_strobe_q, cycle_strobe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  logic [7:0]        mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;

  logic        rise, fall;
  logic [15:0] rd_addr, commit_addr;
  logic [7:0]  rd_data;

  // 17-bit compare keeps a window near the top of memory from wrapping to $0000
  function automatic logic is_mapped(input logic [15:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic is_vector(input logic [15:0] a);
    return VEC_EN && ((a == 16'hFFFC) || (a == 16'hFFFD));
  endfunction

  function automatic logic [ADDR_W-1:0] ram_idx(input logic [15:0] a);
    return ADDR_W'(a - BASE);
  endfunction

  assign rise        = phi & ~phi_q;
  assign fall        = ~phi & phi_q;
  assign rd_addr     = {ab_mux, lo_q};
  assign commit_addr = {hi_q, lo_q};
  assign mem_idx     = ram_idx(commit_addr);

  always_comb begin
    rd_data = FILL;
    if (is_vector(rd_addr))
      rd_data = rd_addr[0] ? RESET_VEC[15:8] : RESET_VEC[7:0];
    else if (is_mapped(rd_addr))
      rd_data = mem_q[ram_idx(rd_addr)];
  end

  always_comb begin
    state_d        = state_q;
    lo_d           = lo_q;
    hi_d           = hi_q;
    wd_d           = wd_q;
    rw_d           = rw_q;
    data_out_d     = data_out_q;
    data_oe_d      = data_oe_q;
    addr_d         = addr_q;
    rw_out_d       = rw_out_q;
    cycle_strobe_d = 1'b0;
    wr_strobe_d    = 1'b0;
    cycle_count_d  = cycle_count_q;
    mem_we         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!phi) begin
          lo_d    = ab_mux;
          rw_d    = bus_in[0];
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (!phi) begin
          lo_d = ab_mux;
          rw_d = bus_in[0];
        end else if (rise) begin
          hi_d       = ab_mux;
          wd_d       = bus_in;
          data_out_d = rd_data;
          data_oe_d  = rw_q;
          state_d    = S_HI;
        end
      end
      S_HI: begin
        if (fall) begin
          cycle_strobe_d = 1'b1;
          addr_d         = commit_addr;
          rw_out_d       = rw_q;
          cycle_count_d  = cycle_count_q + 16'd1;
          data_oe_d      = 1'b0;
          lo_d           = ab_mux;
          rw_d           = bus_in[0];
          state_d        = S_LO;
          if (!rw_q && is_mapped(commit_addr) && !is_vector(commit_addr)) begin
            mem_we      = 1'b1;
            wr_strobe_d = 1'b1;
          end
        end else begin
          hi_d       = ab_mux;
          wd_d       = bus_in;
          data_out_d = rd_data;
          data_oe_d  = rw_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      phi_q          <= 1'b0;
      lo_q           <= 8'h00;
      hi_q           <= 8'h00;
      wd_q           <= 8'h00;
      rw_q           <= 1'b1;
      data_out_q     <= 8'h00;
      data_oe_q      <= 1'b0;
      addr_q         <= 16'h0000;
      rw_out_q       <= 1'b1;
      cycle_strobe_q <= 1'b0;
      wr_strobe_q    <= 1'b0;
      cycle_count_q  <= 16'h0000;
    end else begin
      state_q        <= state_d;
      phi_q          <= phi;
      lo_q           <= lo_d;
      hi_q           <= hi_d;
      wd_q           <= wd_d;
      rw_q           <= rw_d;
      data_out_q     <= data_out_d;
      data_oe_q      <= data_oe_d;
      addr_q         <= addr_d;
      rw_out_q       <= rw_out_d;
      cycle_strobe_q <= cycle_strobe_d;
      wr_strobe_q    <= wr_strobe_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  // RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_idx] <= wd_q;
  end

  assign data_out     = data_out_q;
  assign data_oe      = data_oe_q;
  assign addr         = addr_q;
  assign rw_out       = rw_out_q;
  assign cycle_strobe = cycle_strobe_q;
  assign wr_strobe    = wr_strobe_q;
  assign cycle_count  = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// Testbench for bus_responder: random and directed bus cycles checked by a queue scoreboard.
module tb_bus_responder;

  localparam logic [15:0] BASE   = 16'h0000;
  localparam int          ADDR_W = 8;
  localparam logic [7:0]  FILL   = 8'hEA;
  localparam logic [15:0] RV     = 16'h8000;

  logic        clk = 1'b0;
  logic        rst;
  logic        phi;
  logic [7:0]  ab_mux, bus_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr;
  logic        rw_out, cycle_strobe, wr_strobe;
  logic [15:0] cycle_count;

  bus_responder #(.BASE(BASE), .ADDR_W(ADDR_W), .FILL(FILL), .RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst), .phi(phi), .ab_mux(ab_mux), .bus_in(bus_in),
    .data_out(data_out), .data_oe(data_oe), .addr(addr), .rw_out(rw_out),
    .cycle_strobe(cycle_strobe), .wr_strobe(wr_strobe), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [15:0] cnt;
    logic        wr;
    logic [7:0]  rd;
    logic        chk_rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model_mem [256];
  bit          known [256];
  logic [15:0] model_count;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit m_mapped(input int a);
    return (a >= int'(BASE)) && (a < int'(BASE) + (1 << ADDR_W));
  endfunction

  function automatic bit m_vec(input int a);
`ifdef BUS_RESPONDER_VECTOR_EN
    return (a == 16'hFFFC) || (a == 16'hFFFD);
`else
    return (a < 0);
`endif
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (m_vec(a)) return (a == 16'hFFFC) ? RV[7:0] : RV[15:8];
    if (m_mapped(a)) return model_mem[a - int'(BASE)];
    return FILL;
  endfunction

  task automatic drive_phase(input logic p, input logic [7:0] ab, input logic [7:0] bi, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      phi = p; ab_mux = ab; bus_in = bi;
    end
  endtask

  // Model the access at issue time; the DUT commits it on the next falling phi.
  task automatic issue(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                       input int lo_n, input int hi_n);
    exp_t e;
    int   ai = int'(a);
    e.a      = a;
    e.rw     = rw;
    model_count = model_count + 16'd1;
    e.cnt    = model_count;
    e.rd     = m_read(ai);
    e.chk_rd = rw && (!m_mapped(ai) || m_vec(ai) || known[ai - int'(BASE)]);
    e.wr     = !rw && m_mapped(ai) && !m_vec(ai);
    if (e.wr) begin
      model_mem[ai - int'(BASE)] = wd;
      known[ai - int'(BASE)]     = 1'b1;
    end
    exp_q.push_back(e);
    drive_phase(1'b0, a[7:0], {7'b0, rw}, lo_n);
    drive_phase(1'b1, a[15:8], wd, hi_n);
  endtask

  task automatic flush();
    drive_phase(1'b0, 8'h00, 8'h01, 2);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: actual %0d cycles outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: samples 2 time units after each rising edge
  logic prev_oe = 1'b0;
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (!rst) begin
      if (!phi) chk("oe_low_in_lo", data_oe, 1'b0);
      if (cycle_strobe) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", cycle_strobe, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("addr", addr, e.a);
          chk("rw_out", rw_out, e.rw);
          chk("cycle_count", cycle_count, e.cnt);
          chk("wr_strobe", wr_strobe, e.wr);
          chk("oe_in_hi", prev_oe, e.rw);
          if (e.chk_rd) chk("read_data", data_out, e.rd);
        end
      end else if (wr_strobe) begin
        chk("wr_without_cycle", wr_strobe, 1'b0);
      end
      prev_oe = data_oe;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  old40;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    model_count = 16'h0000;
    rst = 1'b1; phi = 1'b0; ab_mux = 8'h00; bus_in = 8'h01;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_oe", data_oe, 1'b0);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_rw_out", rw_out, 1'b1);
    chk("rst_cycle_strobe", cycle_strobe, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_cycle_count", cycle_count, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_addr", addr, 16'h0000);
    chk("post_rst_rw_out", rw_out, 1'b1);

    repeat (4) issue(16'h0000, 1'b1, 8'h00, 2, 2);
    flush();
    drain("idle_drain");
    chk("idle_count4", cycle_count, 16'd4);

    for (int i = 0; i < 256; i++)
      issue(16'(i), 1'b0, 8'($urandom), 1 + int'($urandom_range(1)), 2);

    issue(16'h0012, 1'b0, 8'h5A, 2, 2);
    issue(16'h0012, 1'b1, 8'h00, 2, 2);
    issue(16'h1234, 1'b0, 8'h33, 2, 2);
    issue(16'h1234, 1'b1, 8'h00, 2, 2);
    issue(16'hFFFC, 1'b1, 8'h00, 2, 2);
    issue(16'hFFFD, 1'b1, 8'h00, 2, 2);
    issue(16'hFFFC, 1'b0, 8'h11, 1, 2);
    issue(16'hFFFC, 1'b1, 8'h00, 1, 3);
    issue(16'h00FF, 1'b0, 8'hC3, 1, 2);
    issue(16'h0100, 1'b1, 8'h00, 1, 2);
    issue(16'h00FF, 1'b1, 8'h00, 1, 2);

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      if ($urandom_range(3) != 0) a[15:8] = 8'h00;
      if ($urandom_range(15) == 0) a = 16'hFFFC | 16'($urandom_range(1));
      issue(a, 1'($urandom), 8'($urandom),
            1 + int'($urandom_range(2)), 2 + int'($urandom_range(2)));
    end
    flush();
    drain("random_drain");

    // Reset during the HI phase of a write to $0040: the write must vanish
    old40 = model_mem[8'h40];
    drive_phase(1'b0, 8'h40, 8'h00, 2);
    drive_phase(1'b1, 8'h00, ~old40, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_count", cycle_count, 16'h0000);
    chk("midrst_oe", data_oe, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_count = 16'h0000;
    repeat (2) @(negedge clk);
    chk("idle_after_rst_count", cycle_count, 16'h0000);
    issue(16'h0040, 1'b1, 8'h00, 2, 2);
    flush();
    drain("midrst_drain");
    chk("resume_count1", cycle_count, 16'd1);
    chk("mem40_kept", model_mem[8'h40], old40);

    // Wrap of the cycle counter from $FFFF
    @(negedge clk);
    force dut.cycle_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.cycle_count_q;
    model_count = 16'hFFFF;
    issue(16'h0012, 1'b1, 8'h00, 2, 2);
    flush();
    drain("wrap_drain");
    chk("wrap_count", cycle_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the multiplexed external bus driven by the tt_um_6502 core. It demultiplexes the 16-bit address from the 8-bit address pins, using the phase of the CPU clock to tell the bytes apart. It also captures the read/write flag and write data, services the access from an internal byte RAM, and drives read data back onto the core's bidirectional data pins. It sits outside the core, in the test harness or a companion FPGA, and uses the same fast `clk` that feeds the core's clock generator.

## Interface
- `BASE`, 16'h0000: first CPU address mapped to the internal RAM.
- `ADDR_W`, 8: log2 of RAM depth in bytes (256 by default).
- `FILL`, 8'hEA: read value for unmapped addresses (6502 NOP).
- `RESET_VEC`, 16'h0000: vector returned at $FFFC/$FFFD when `BUS_RESPONDER_VECTOR_EN` is defined.
- `clk`, input, 1: fast system clock; all state changes on posedge.
- `rst`, input, 1: asynchronous, active-high reset.
- `phi`, input, 1: CPU clock level (`clk_cpu`), same domain as `clk`, no synchroniser.
- `ab_mux`, input, 8: core address pins; low byte while `phi`=0, high byte while `phi`=1.
- `bus_in`, input, 8: core data pins.
  - `phi`=0: bit0 = rw (1 = read).
  - `phi`=1: write data.
- `data_out`, output, 8: read data toward the core data inputs.
- `data_oe`, output, 1: responder drives `data_out`.
- `addr`, output, 16: address of the last completed cycle.
- `rw_out`, output, 1: rw of the last completed cycle.
- `cycle_strobe`, output, 1: one-`clk` pulse when a bus cycle completes.
- `wr_strobe`, output, 1: one-`clk` pulse when a write is committed to RAM.
- `cycle_count`, output, 16: completed bus cycles, wraps $FFFF to $0000.

## Operation
- Edge detect: `phi_q` <= `phi` each `clk`.
  - rise = `phi` & !`phi_q`.
  - fall = !`phi` & `phi_q`.
- IDLE, entered on reset.
  - Outputs are held.
  - Go to LO on the first `clk` with `phi`=0.
  - No cycle is counted for the partial phase.
- LO (`phi`=0):
  - Every `clk`: `lo_reg` <= `ab_mux`; `rw_reg` <= `bus_in[0]`.
  - Last value wins.
  - On rise, go to HI.
- HI (`phi`=1):
  - Every `clk`: `hi_reg` <= `ab_mux`; `wd_reg` <= `bus_in`.
  - Every `clk`: `data_out` <= read({`ab_mux`, `lo_reg`}).
  - `data_oe` = `rw_reg`.
- HI to LO on fall. In that same edge:
  - Commit the cycle using `hi_reg`, `lo_reg`, `rw_reg` and `wd_reg`; these hold the values from the last HI `clk`.
  - Pulse `cycle_strobe`.
  - Update `addr`/`rw_out` and increment `cycle_count`.
  - Capture the new `lo_reg`.
  - `data_oe` <= 0.
- Write commit (`rw_reg`=0):
  - If the address is mapped, `mem[addr-BASE]` <= `wd_reg` and `wr_strobe` pulses.
  - Unmapped writes are dropped and `wr_strobe` stays 0.
- Read:
  - Mapped when BASE <= a < BASE + 2^ADDR_W; computed in 17-bit arithmetic so the window cannot wrap past $FFFF.
  - Mapped addresses return `mem[a-BASE]`; unmapped return `FILL`.
- RAM contents are not cleared by reset.

## Timing
- Reset values:
  - State = IDLE.
  - `data_out`=0, `data_oe`=0, `addr`=0, `rw_out`=1.
  - `cycle_strobe`=0, `wr_strobe`=0, `cycle_count`=0, `phi_q`=0.
- Read latency: `data_out` is valid 1 `clk` after the high address byte appears. HI must therefore last at least 2 `clk` for data to be valid before the core's falling `phi` edge.
- LO must last at least 1 `clk`. A shorter phase is not detected; the result is undefined.
- Simultaneous events:
  - Reset asserted mid-cycle abandons the cycle; no write, no strobe.
  - After release, the block returns to IDLE and resynchronises.
- Write-then-read to the same address in consecutive cycles returns the new data; the commit precedes the next HI read by at least 1 `clk`.
- `cycle_count` wraps silently; no overflow flag.

## Configuration
- `BUS_RESPONDER_VECTOR_EN` defined:
  - Reads of $FFFC return `RESET_VEC[7:0]`; reads of $FFFD return `RESET_VEC[15:8]`. This overrides the RAM/`FILL` result.
  - Writes to those addresses are dropped with no `wr_strobe`.
- Undefined: $FFFC/$FFFD behave as ordinary addresses, mapped or unmapped per `BASE`/`ADDR_W`.

## Test plan
- Reset, then 4 idle `phi` periods (2 `clk` low / 2 `clk` high):
  - `addr`=0 with `rw_out`=1 immediately after reset.
  - `cycle_count`=4 after the 4th fall.
  - `data_oe` high only in HI phases of read cycles.
- Write $5A to $0012 (lo=$12, rw=0, hi=$00, data=$5A), then read $0012:
  - `wr_strobe` pulses once.
  - Read cycle returns `data_out`=$5A with `data_oe`=1 in HI.
- Write $33 to $1234 with `BASE`=0 and `ADDR_W`=8:
  - No `wr_strobe`.
  - Subsequent read of $1234 returns $EA.
- Read $FFFC/$FFFD with `RESET_VEC`=$8000:
  - Macro defined: returns $00 then $80.
  - Macro undefined: returns $EA twice.
- Assert `rst` during the HI phase of a write to $0040:
  - `mem[$40]` unchanged and no strobes.
  - After release and one `phi` cycle, normal operation resumes with `cycle_count`=1.
- Preload `cycle_count` to $FFFF via 65535 cycles (or force), run one more cycle: `cycle_count`=$0000 and `cycle_strobe` pulses.
